// File: rtl/cache_mem_arbiter_if.sv
// ============================================================================
// Module   : cache_mem_arbiter_if
// Brief    : I-cache / D-cache miss ports and cacheline-adaptor port bundle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface cache_mem_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_read_i;
    logic [LINE_W-1:0] i_line_o;
    logic              i_resp_o;

    logic [ADDR_W-1:0] d_addr_i;
    logic              d_read_i;
    logic              d_write_i;
    logic [LINE_W-1:0] d_line_i;
    logic [LINE_W-1:0] d_line_o;
    logic              d_resp_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [LINE_W-1:0] mem_line_o;
    logic [LINE_W-1:0] mem_line_i;
    logic              mem_resp_i;

    // Arbiter view
    modport master (
        input  i_addr_i, i_read_i, d_addr_i, d_read_i, d_write_i, d_line_i,
               mem_line_i, mem_resp_i,
        output i_line_o, i_resp_o, d_line_o, d_resp_o,
               mem_addr_o, mem_read_o, mem_write_o, mem_line_o
    );

    // Cache / adaptor view
    modport slave (
        output i_addr_i, i_read_i, d_addr_i, d_read_i, d_write_i, d_line_i,
               mem_line_i, mem_resp_i,
        input  i_line_o, i_resp_o, d_line_o, d_resp_o,
               mem_addr_o, mem_read_o, mem_write_o, mem_line_o
    );
endinterface

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// Module   : cache_mem_arbiter
// Brief    : Round-robin arbiter sharing one cacheline adaptor between the
//            I-cache and D-cache. Optional macro ARB_PERF_CNT_EN adds grant
//            and contention counters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cache_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]          i_grant_cnt_o,
    output logic [31:0]          d_grant_cnt_o,
    output logic [31:0]          contend_cnt_o,
`endif
    cache_mem_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE_I = 2'd1,
        S_SERVE_D = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_last_d;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_line;
    logic              r_mem_read;
    logic              r_mem_write;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_busy;

    assign w_i_req   = bus.i_read_i;
    assign w_d_req   = bus.d_read_i | bus.d_write_i;
    // On a tie, the side that did not win last time gets the line
    assign w_grant_i = (r_state == S_IDLE) & w_i_req & (~w_d_req | r_last_d);
    assign w_grant_d = (r_state == S_IDLE) & w_d_req & (~w_i_req | ~r_last_d);
    assign w_busy    = r_mem_read | r_mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_d    <= 1'b1;
            r_addr      <= '0;
            r_line      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_i) begin
                        r_state     <= S_SERVE_I;
                        r_last_d    <= 1'b0;
                        r_addr      <= bus.i_addr_i;
                        r_line      <= '0;
                        r_mem_read  <= 1'b1;
                        r_mem_write <= 1'b0;
                    end else if (w_grant_d) begin
                        r_state     <= S_SERVE_D;
                        r_last_d    <= 1'b1;
                        r_addr      <= bus.d_addr_i;
                        r_line      <= bus.d_write_i ? bus.d_line_i : '0;
                        r_mem_read  <= ~bus.d_write_i;
                        r_mem_write <= bus.d_write_i;
                    end
                end
                S_SERVE_I, S_SERVE_D: begin
                    if (bus.mem_resp_i) begin
                        r_state     <= S_RECOVER;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end
                end
                S_RECOVER: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Adaptor side only sees latched values while a transaction is open
    assign bus.mem_addr_o  = w_busy ? r_addr : '0;
    assign bus.mem_read_o  = r_mem_read;
    assign bus.mem_write_o = r_mem_write;
    assign bus.mem_line_o  = r_mem_write ? r_line : '0;

    always_comb begin
        bus.i_resp_o = 1'b0;
        bus.i_line_o = '0;
        bus.d_resp_o = 1'b0;
        bus.d_line_o = '0;
        if (bus.mem_resp_i) begin
            if (r_state == S_SERVE_I) begin
                bus.i_resp_o = 1'b1;
                bus.i_line_o = bus.mem_line_i;
            end else if (r_state == S_SERVE_D) begin
                bus.d_resp_o = 1'b1;
                bus.d_line_o = bus.mem_line_i;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_i_grant_cnt;
    logic [31:0] r_d_grant_cnt;
    logic [31:0] r_contend_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_grant_cnt <= '0;
            r_d_grant_cnt <= '0;
            r_contend_cnt <= '0;
        end else begin
            if (w_grant_i) begin
                r_i_grant_cnt <= r_i_grant_cnt + 32'd1;
            end
            if (w_grant_d) begin
                r_d_grant_cnt <= r_d_grant_cnt + 32'd1;
            end
            if ((r_state == S_IDLE) && w_i_req && w_d_req) begin
                r_contend_cnt <= r_contend_cnt + 32'd1;
            end
        end
    end

    assign i_grant_cnt_o = r_i_grant_cnt;
    assign d_grant_cnt_o = r_d_grant_cnt;
    assign contend_cnt_o = r_contend_cnt;
`endif

endmodule

`default_nettype wire
